// File: rtl/ex_unit.sv
// ============================================================================
// Module   : ex_unit
// Brief    : Execute stage with ALU, quick-compare, iterative shifter and
//            valid/ready-handshaked EX/MEM result register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_unit #(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic [7:0]   ALUsel,
    input  logic [5:0]   QCsel,
    input  logic         UseImm,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [W-1:0] imm,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         taken,
    output logic         busy
);

    localparam logic [7:0] SEL_ALU_DC8  = 8'd0;
    localparam logic [7:0] SEL_ALU_ADD  = 8'd1;
    localparam logic [7:0] SEL_ALU_SUB  = 8'd2;
    localparam logic [7:0] SEL_ALU_SLT  = 8'd3;
    localparam logic [7:0] SEL_ALU_SLTU = 8'd4;
    localparam logic [7:0] SEL_ALU_AND  = 8'd5;
    localparam logic [7:0] SEL_ALU_OR   = 8'd6;
    localparam logic [7:0] SEL_ALU_XOR  = 8'd7;
    localparam logic [7:0] SEL_ALU_NOR  = 8'd8;
    localparam logic [7:0] SEL_ALU_SLL  = 8'd9;
    localparam logic [7:0] SEL_ALU_SRL  = 8'd10;
    localparam logic [7:0] SEL_ALU_SRA  = 8'd11;

    localparam logic [5:0] SEL_QC_EQ  = 6'b000001;
    localparam logic [5:0] SEL_QC_NE  = 6'b000010;
    localparam logic [5:0] SEL_QC_LEZ = 6'b000100;
    localparam logic [5:0] SEL_QC_GTZ = 6'b001000;
    localparam logic [5:0] SEL_QC_LTZ = 6'b010000;
    localparam logic [5:0] SEL_QC_GEZ = 6'b100000;

    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_RL = 2'd1;
    localparam logic [1:0] SH_RA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  result_q;
    logic          ovf_q, taken_q, valid_q, busy_q;
    logic [SW-1:0] cnt_q;
    logic [1:0]    shkind_q;

    logic [W-1:0]  opb_w, sum_w, diff_w, alu_res_w, shifted_w;
    logic [SW-1:0] shamt_w;
    logic          alu_ovf_w, is_shift_w, qc_w, accept_w;
    logic [1:0]    shkind_w;

    assign ready_out = ~reset & ~flush &
                       ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & ready_in));
    assign accept_w  = valid_in & ready_out;

    assign opb_w   = UseImm ? imm : rt_data;
    assign shamt_w = UseImm ? imm[6 +: SW] : rs_data[SW-1:0];
    assign sum_w   = rs_data + opb_w;
    assign diff_w  = rs_data - opb_w;

    always_comb begin
        alu_res_w  = '0;
        alu_ovf_w  = 1'b0;
        is_shift_w = 1'b0;
        shkind_w   = SH_LL;
        case (ALUsel)
            SEL_ALU_ADD: begin
                alu_res_w = sum_w;
                alu_ovf_w = (rs_data[W-1] == opb_w[W-1]) & (sum_w[W-1] != rs_data[W-1]);
            end
            SEL_ALU_SUB: begin
                alu_res_w = diff_w;
                alu_ovf_w = (rs_data[W-1] != opb_w[W-1]) & (diff_w[W-1] != rs_data[W-1]);
            end
            SEL_ALU_SLT:  alu_res_w = {{(W-1){1'b0}}, $signed(rs_data) < $signed(opb_w)};
            SEL_ALU_SLTU: alu_res_w = {{(W-1){1'b0}}, rs_data < opb_w};
            SEL_ALU_AND:  alu_res_w = rs_data & opb_w;
            SEL_ALU_OR:   alu_res_w = rs_data | opb_w;
            SEL_ALU_XOR:  alu_res_w = rs_data ^ opb_w;
            SEL_ALU_NOR:  alu_res_w = ~(rs_data | opb_w);
            SEL_ALU_SLL:  begin is_shift_w = 1'b1; shkind_w = SH_LL; end
            SEL_ALU_SRL:  begin is_shift_w = 1'b1; shkind_w = SH_RL; end
            SEL_ALU_SRA:  begin is_shift_w = 1'b1; shkind_w = SH_RA; end
            SEL_ALU_DC8:  alu_res_w = '0;
            default:      alu_res_w = '0;
        endcase
    end

    always_comb begin
        qc_w = 1'b0;
        case (QCsel)
            SEL_QC_EQ:  qc_w = (rs_data == rt_data);
            SEL_QC_NE:  qc_w = (rs_data != rt_data);
            SEL_QC_LEZ: qc_w = rs_data[W-1] | (rs_data == '0);
            SEL_QC_GTZ: qc_w = ~rs_data[W-1] & (rs_data != '0);
            SEL_QC_LTZ: qc_w = rs_data[W-1];
            SEL_QC_GEZ: qc_w = ~rs_data[W-1];
            default:    qc_w = 1'b0;
        endcase
    end

    // The result register doubles as the shift register while in SHIFT.
    always_comb begin
        shifted_w = {result_q[W-2:0], 1'b0};
        if (shkind_q == SH_RL) shifted_w = {1'b0, result_q[W-1:1]};
        if (shkind_q == SH_RA) shifted_w = {result_q[W-1], result_q[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            taken_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            shkind_q <= SH_LL;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept_w) begin
                        taken_q <= qc_w;
                        if (is_shift_w) begin
                            result_q <= rt_data;
                            ovf_q    <= 1'b0;
                            cnt_q    <= shamt_w;
                            shkind_q <= shkind_w;
                            if (shamt_w == '0) begin
                                state_q <= ST_HOLD;
                                valid_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_SHIFT;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            result_q <= alu_res_w;
                            ovf_q    <= alu_ovf_w;
                            state_q  <= ST_HOLD;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    end else if ((state_q == ST_HOLD) && ready_in) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    result_q <= shifted_w;
                    cnt_q    <= cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        state_q <= ST_HOLD;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign ovf       = ovf_q;
    assign taken     = taken_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Execute-stage consumer of the decoded stage-3 controls `ALUsel`, `QCsel` and `UseImm`.
- Selects operands, performs the ALU operation and the branch quick-compare, and registers the result into the EX/MEM latch.
- Shifts use an iterative 1-bit-per-cycle shifter, so the unit has a valid/ready handshake on both sides.
- Sits between the decode/EX control logic and the MEM stage.

Parameters:
- W, 32: datapath width.
- SW, 5: shift-amount width (log2 W).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of any in-flight or held op
- valid_in  input  1  upstream op present
- ready_out  output  1  unit can accept an op this cycle
- ALUsel  input  8  ALU select, uses the `select_alu_*` codes from mips.h
- QCsel  input  6  quick-compare select, uses the `select_qc_*` codes
- UseImm  input  1  B operand = imm; shift amount = imm[10:6]
- rs_data  input  W  source operand A
- rt_data  input  W  source operand B / shift source
- imm  input  W  immediate, already extended; LUI value already shifted upstream
- valid_out  output  1  result register holds a valid op
- ready_in  input  1  MEM stage accepts the result
- result  output  W  ALU result
- ovf  output  1  signed overflow of add/sub
- taken  output  1  quick-compare outcome
- busy  output  1  iterative shift in progress

Behaviour:
- Reset: `valid_out`=0, `result`=0, `ovf`=0, `taken`=0, `busy`=0, state=IDLE.
- FSM states: IDLE, SHIFT, HOLD.
- `ready_out` = (state==IDLE) | (state==HOLD & ready_in). This allows back-to-back issue through HOLD.
- Accept occurs when `valid_in` & `ready_out`.
- Operand B = UseImm ? imm : rt_data.
- Shift amount = UseImm ? imm[10:6] : rs_data[4:0]. The shifted value is rt_data.
- Non-shift ops (add, sub, slt, sltu, and, or, xor, nor):
  - Result is computed combinationally and registered on accept.
  - Next state HOLD, `valid_out`=1. Latency is 1 cycle.
- Arithmetic rules:
  - add/sub are modulo 2^W.
  - `ovf` = signed overflow for add/sub, 0 for all other ops.
  - slt is a signed compare, sltu unsigned; the result is zero-extended 0/1.
- Shift ops (sll, srl, sra):
  - On accept, load the shifter with rt_data and a counter with the amount.
  - If the amount is 0, go directly to HOLD; latency is 1 cycle.
  - Otherwise go to SHIFT with `busy`=1. Shift by one bit per cycle, decrementing the counter.
  - When the counter reaches 0, go to HOLD. Total latency is amount+1 cycles.
  - srl fills with 0; sra replicates bit W-1.
- ALUsel equal to `dc8` or any unknown code: the op still flows; `result`=0, `ovf`=0.
- Quick compare:
  - Evaluated at accept time, registered with the result.
  - eq: rs==rt. ne: rs!=rt.
  - lez: rs[W-1] | rs==0. gtz: !rs[W-1] & rs!=0.
  - ltz: rs[W-1]. gez: !rs[W-1].
  - `dc6` or unknown code: `taken`=0.
- HOLD:
  - Outputs are stable while ready_in=0.
  - On ready_in=1 with no new accept: clear `valid_out`, go to IDLE.
  - On ready_in=1 with a new accept in the same cycle: load the new op; `valid_out` stays 1 for a non-shift op, or drops to 0 for a shift op.
- No new op is accepted while in SHIFT.
- `flush`:
  - Forces state=IDLE, `valid_out`=0, `busy`=0 next cycle.
  - `result`, `ovf` and `taken` are cleared to 0.
  - A simultaneous `valid_in` is discarded.
  - `ready_out` is 0 in a flush cycle.
- Priority: reset > flush > normal operation.
- No output may change mid-HOLD except on handshake, flush or reset.

Test Plan:
- Add overflow: reset, then ALUsel=add, rs=0x7FFFFFFF, rt=1, UseImm=0, ready_in=1 -> next cycle `valid_out`=1, `result`=0x80000000, `ovf`=1.
- Arithmetic shift with backpressure: ALUsel=sra, UseImm=1, imm[10:6]=4, rt=0x80000000 -> `busy`=1 for 4 cycles, `valid_out` on cycle 5, `result`=0xF8000000. Hold ready_in=0 for 3 cycles -> `result` stable, `ready_out`=0.
- Zero-amount shift: ALUsel=sllv, rs=0x20 (amount 0), rt=0x1234 -> `result`=0x1234 after 1 cycle, `busy` never asserted.
- Back-to-back issue in HOLD: slt with rs=0xFFFFFFFF, rt=1 -> `result`=1. Then sltu with the same operands issued in the same cycle the MEM stage accepts -> next `result`=0, `valid_out` continuous.
- Quick compare: QCsel=lez, rs=0 -> `taken`=1. QCsel=gtz, rs=0 -> `taken`=0. QCsel=ne, rs=5, rt=5 -> `taken`=0.
- Mid-operation kills: sll by 20 with flush on cycle 3 -> next cycle `busy`=0, `valid_out`=0, `ready_out`=1, no result ever emitted. Repeat with reset instead of flush -> same outcome.
